// File: rtl/memory_writeback_cycle_if.sv
// EX/MEM -> MEM/WB bundle for the memory-access / write-back stage.
// The pipeline (master) drives the M-side fields and observes the W-side
// results; the stage (slave) consumes the M fields and produces the W fields.
interface memory_writeback_cycle_if;
    // EX/MEM side
    logic        RegWriteM;
    logic        MemWriteM;
    logic        ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] ALU_ResultM;
    logic [31:0] WriteDataM;
    logic [31:0] PCPlus4M;

    // MEM/WB side
    logic        RegWriteW;
    logic        ResultSrcW;
    logic [4:0]  RD_W;
    logic [31:0] ALU_ResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCPlus4W;
    logic [31:0] ResultW;
    logic        MemFault;

    modport master (
        output RegWriteM, MemWriteM, ResultSrcM, RD_M, ALU_ResultM, WriteDataM, PCPlus4M,
        input  RegWriteW, ResultSrcW, RD_W, ALU_ResultW, ReadDataW, PCPlus4W, ResultW, MemFault
    );

    modport slave (
        input  RegWriteM, MemWriteM, ResultSrcM, RD_M, ALU_ResultM, WriteDataM, PCPlus4M,
        output RegWriteW, ResultSrcW, RD_W, ALU_ResultW, ReadDataW, PCPlus4W, ResultW, MemFault
    );
endinterface

// File: rtl/memory_writeback_cycle.sv
// Memory-access and write-back stage of the 5-stage RV32 pipeline.
// Holds a word-addressed data memory (read combinationally, written on the
// clock edge) and the MEM/WB pipeline register. Illegal accesses (misaligned
// or beyond the memory) are suppressed and latch a sticky MemFault flag.
module memory_writeback_cycle #(
    parameter int DMEM_AW = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    memory_writeback_cycle_if.slave bus
);

    localparam int DEPTH = 1 << DMEM_AW;

    logic [31:0]        mem [DEPTH];
    logic [DMEM_AW-1:0] word_idx;
    logic [31:0]        read_data_m;
    logic               misaligned;
    logic               out_of_range;
    logic               addr_bad;
    logic               store_ok;
    logic               store_bad;
    logic               load_bad;

    assign word_idx = bus.ALU_ResultM[DMEM_AW+1:2];

    // Address legality: word aligned and no bits set above the memory span.
    // The shift form keeps this valid for any DMEM_AW without a zero-width slice.
    assign misaligned   = |bus.ALU_ResultM[1:0];
    assign out_of_range = (bus.ALU_ResultM >> (DMEM_AW + 2)) != 32'h0;
    assign addr_bad     = misaligned | out_of_range;

    assign store_ok  = bus.MemWriteM & ~addr_bad;
    assign store_bad = bus.MemWriteM & addr_bad;
    assign load_bad  = bus.ResultSrcM & addr_bad;

    // Read port is always live; a colliding store lands on the edge, so the
    // same-cycle read sees the old contents (read-before-write).
    assign read_data_m = mem[word_idx];

    // Data memory: cleared by reset, full-word stores only when legal.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (store_ok) begin
            mem[word_idx] <= bus.WriteDataM;
        end
    end

    // MEM/WB pipeline register: loads every cycle, no stall/flush.
    // An illegal load still writes back, with zero as its data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.RegWriteW   <= 1'b0;
            bus.ResultSrcW  <= 1'b0;
            bus.RD_W        <= 5'd0;
            bus.ALU_ResultW <= 32'h0;
            bus.ReadDataW   <= 32'h0;
            bus.PCPlus4W    <= 32'h0;
        end else begin
            bus.RegWriteW   <= bus.RegWriteM;
            bus.ResultSrcW  <= bus.ResultSrcM;
            bus.RD_W        <= bus.RD_M;
            bus.ALU_ResultW <= bus.ALU_ResultM;
            bus.ReadDataW   <= load_bad ? 32'h0 : read_data_m;
            bus.PCPlus4W    <= bus.PCPlus4M;
        end
    end

    // Sticky fault flag: set by any illegal load or store, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.MemFault <= 1'b0;
        end else if (store_bad | load_bad) begin
            bus.MemFault <= 1'b1;
        end
    end

    // Write-back mux, valid in the same cycle as the W registers.
    assign bus.ResultW = bus.ResultSrcW ? bus.ReadDataW : bus.ALU_ResultW;

endmodule

// File: tb/tb_memory_writeback_cycle.sv
// Directed bench for memory_writeback_cycle: hand-computed expectations,
// immediate assertions at each comparison point.
module tb_memory_writeback_cycle;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    memory_writeback_cycle_if bus ();

    memory_writeback_cycle #(.DMEM_AW(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] pc4);
        bus.RegWriteM   = rw;
        bus.MemWriteM   = mw;
        bus.ResultSrcM  = rs;
        bus.RD_M        = rd;
        bus.ALU_ResultM = addr;
        bus.WriteDataM  = wd;
        bus.PCPlus4M    = pc4;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        idle();
        step();
        step();

        // Reset state
        chk("rst_regwrite", {31'b0, bus.RegWriteW}, 32'h0);
        chk("rst_rd",       {27'b0, bus.RD_W}, 32'h0);
        chk("rst_result",   bus.ResultW, 32'h0);
        chk("rst_pc4",      bus.PCPlus4W, 32'h0);
        chk("rst_fault",    {31'b0, bus.MemFault}, 32'h0);

        reset = 1'b1;

        // Store then load same word on consecutive cycles
        drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h10, 32'hDEADBEEF, 32'h4);
        step();
        drive(1'b1, 1'b0, 1'b1, 5'd5, 32'h10, 32'h0, 32'h8);
        step();
        chk("sl_readdata", bus.ReadDataW, 32'hDEADBEEF);
        chk("sl_result",   bus.ResultW, 32'hDEADBEEF);
        chk("sl_rd",       {27'b0, bus.RD_W}, 32'd5);
        chk("sl_regwrite", {31'b0, bus.RegWriteW}, 32'd1);
        chk("sl_pc4",      bus.PCPlus4W, 32'h8);

        // ALU pass-through (address would be illegal, but no access requested)
        drive(1'b1, 1'b0, 1'b0, 5'd7, 32'h12345678, 32'h0, 32'h100);
        step();
        chk("alu_result", bus.ResultW, 32'h12345678);
        chk("alu_rd",     {27'b0, bus.RD_W}, 32'd7);
        chk("alu_pc4",    bus.PCPlus4W, 32'h100);
        chk("alu_nofault", {31'b0, bus.MemFault}, 32'h0);

        // Memory untouched by the pass-through
        drive(1'b1, 1'b0, 1'b1, 5'd1, 32'h10, 32'h0, 32'h0);
        step();
        chk("alu_memkeep", bus.ResultW, 32'hDEADBEEF);

        // Simultaneous store+load: read-before-write, store commits
        drive(1'b1, 1'b1, 1'b1, 5'd2, 32'h10, 32'h11111111, 32'h0);
        step();
        chk("rbw_old", bus.ReadDataW, 32'hDEADBEEF);
        drive(1'b1, 1'b0, 1'b1, 5'd2, 32'h10, 32'h0, 32'h0);
        step();
        chk("rbw_new", bus.ReadDataW, 32'h11111111);

        // Misaligned store
        drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h22, 32'hFFFFFFFF, 32'h0);
        step();
        chk("mis_fault", {31'b0, bus.MemFault}, 32'd1);
        drive(1'b1, 1'b0, 1'b1, 5'd3, 32'h20, 32'h0, 32'h0);
        step();
        chk("mis_word8", bus.ResultW, 32'h0);
        idle();
        for (int i = 0; i < 10; i++) step();
        chk("mis_sticky", {31'b0, bus.MemFault}, 32'd1);

        // Out-of-range store must not alias onto word 0
        drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h1000, 32'h00000BAD, 32'h0);
        step();
        drive(1'b1, 1'b0, 1'b1, 5'd4, 32'h0, 32'h0, 32'h0);
        step();
        chk("oor_store_word0", bus.ReadDataW, 32'h0);

        // Out-of-range load returns zero (preload nonzero ReadDataW first)
        drive(1'b1, 1'b0, 1'b1, 5'd4, 32'h10, 32'h0, 32'h0);
        step();
        chk("oor_pre", bus.ReadDataW, 32'h11111111);
        drive(1'b1, 1'b0, 1'b1, 5'd4, 32'h1000, 32'h0, 32'h0);
        step();
        chk("oor_load_data", bus.ReadDataW, 32'h0);
        chk("oor_load_wb",   {31'b0, bus.RegWriteW}, 32'd1);
        chk("oor_fault",     {31'b0, bus.MemFault}, 32'd1);

        // Reset mid-operation
        drive(1'b1, 1'b1, 1'b0, 5'd3, 32'h4, 32'hA5A5A5A5, 32'h104);
        step();
        chk("pre_rst_rd", {27'b0, bus.RD_W}, 32'd3);
        drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h8, 32'h5A5A5A5A, 32'h0);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_regwrite", {31'b0, bus.RegWriteW}, 32'h0);
        chk("mid_rst_rd",       {27'b0, bus.RD_W}, 32'h0);
        chk("mid_rst_alu",      bus.ALU_ResultW, 32'h0);
        chk("mid_rst_pc4",      bus.PCPlus4W, 32'h0);
        chk("mid_rst_result",   bus.ResultW, 32'h0);
        chk("mid_rst_fault",    {31'b0, bus.MemFault}, 32'h0);
        step();
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 5'd6, 32'h4, 32'h0, 32'h0);
        step();
        chk("post_rst_w4", bus.ResultW, 32'h0);
        drive(1'b1, 1'b0, 1'b1, 5'd6, 32'h8, 32'h0, 32'h0);
        step();
        chk("post_rst_w8", bus.ResultW, 32'h0);

        // Illegal address with no access request must not fault
        drive(1'b1, 1'b0, 1'b0, 5'd9, 32'h1003, 32'h0, 32'h0);
        step();
        chk("noacc_nofault", {31'b0, bus.MemFault}, 32'h0);
        chk("noacc_result",  bus.ResultW, 32'h1003);

        // Streaming: 16 back-to-back stores then 16 back-to-back loads
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 1'b0, 5'd0, 32'(i * 4), 32'(i), 32'h0);
            step();
        end
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 1'b1, 5'(i + 1), 32'(i * 4), 32'h0, 32'h0);
            step();
            chk($sformatf("stream_ld%0d", i), bus.ResultW, 32'(i));
        end
        chk("stream_nofault", {31'b0, bus.MemFault}, 32'h0);

        idle();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
